// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a small write buffer.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module data_cache #(
    parameter int unsigned INDEX_W  = 6,
    parameter int unsigned WB_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] cpu_addr_i,
    input  logic        cpu_r_en_i,
    input  logic [3:0]  cpu_w_en_i,
    input  logic [31:0] cpu_w_data_i,
    output logic [31:0] cpu_r_data_o,
    output logic        cpu_ready_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_r_en_o,
    output logic [3:0]  mem_w_en_o,
    output logic [31:0] mem_w_data_o,
    input  logic [31:0] mem_r_data_i,
    input  logic        mem_ready_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] stat_hits_o,
    output logic [31:0] stat_misses_o
`endif
);

    localparam int unsigned Lines = 2 ** INDEX_W;
    localparam int unsigned TagW  = 30 - INDEX_W;
    localparam int unsigned PtrW  = $clog2(WB_DEPTH);
    localparam logic [PtrW:0] WbFull = (PtrW + 1)'(WB_DEPTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StDrain = 2'd1;
    localparam logic [1:0] StMiss  = 2'd2;
    localparam logic [1:0] StFill  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [Lines-1:0]   valid_q;
    logic [TagW-1:0]    tag_q  [Lines];
    logic [31:0]        line_q [Lines];

    logic [29:0]        wb_addr_q [WB_DEPTH];
    logic [3:0]         wb_be_q   [WB_DEPTH];
    logic [31:0]        wb_data_q [WB_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]      cnt_q;

    logic [INDEX_W-1:0] idx;
    logic [TagW-1:0]    tag;
    logic               hit, wb_empty, wb_full, wb_drain, wb_push, wb_pop, line_fill;
    logic               unused_addr;

    assign idx         = cpu_addr_i[INDEX_W+1:2];
    assign tag         = cpu_addr_i[31:INDEX_W+2];
    assign unused_addr = ^cpu_addr_i[1:0];
    assign hit         = valid_q[idx] && (tag_q[idx] == tag);

    assign wb_empty  = (cnt_q == '0);
    assign wb_full   = (cnt_q == WbFull);
    assign wb_drain  = !rst_i && (state_q == StIdle || state_q == StDrain) && !wb_empty;
    assign wb_pop    = wb_drain && mem_ready_i;
    // Loads take priority over a simultaneous (illegal) store; a full buffer stalls the store.
    assign wb_push   = !rst_i && (state_q == StIdle) && !cpu_r_en_i && (|cpu_w_en_i) && !wb_full;
    assign line_fill = !rst_i && (state_q == StMiss) && mem_ready_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cpu_r_en_i && !hit) state_d = wb_empty ? StMiss : StDrain;
            StDrain: if (wb_empty) state_d = StMiss;
            StMiss:  if (mem_ready_i) state_d = StFill;
            StFill:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (line_fill) valid_q[idx] <= 1'b1;
            if (wb_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (wb_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            cnt_q <= cnt_q + {{PtrW{1'b0}}, wb_push} - {{PtrW{1'b0}}, wb_pop};
        end
    end

    // Storage arrays carry no reset; validity is tracked by valid_q and the buffer count.
    always_ff @(posedge clk_i) begin
        if (line_fill) begin
            tag_q[idx]  <= tag;
            line_q[idx] <= mem_r_data_i;
        end else if (wb_push && hit) begin
            for (int b = 0; b < 4; b++) begin
                if (cpu_w_en_i[b]) line_q[idx][8*b +: 8] <= cpu_w_data_i[8*b +: 8];
            end
        end
        if (wb_push) begin
            wb_addr_q[wr_ptr_q] <= cpu_addr_i[31:2];
            wb_be_q[wr_ptr_q]   <= cpu_w_en_i;
            wb_data_q[wr_ptr_q] <= cpu_w_data_i;
        end
    end

    always_comb begin
        cpu_ready_o  = 1'b0;
        cpu_r_data_o = '0;
        mem_addr_o   = '0;
        mem_r_en_o   = 1'b0;
        mem_w_en_o   = '0;
        mem_w_data_o = '0;
        if (!rst_i) begin
            unique case (state_q)
                StIdle: begin
                    if (cpu_r_en_i) begin
                        cpu_ready_o = hit;
                        if (hit) cpu_r_data_o = line_q[idx];
                    end else if (|cpu_w_en_i) begin
                        cpu_ready_o = !wb_full;
                    end else begin
                        cpu_ready_o = 1'b1;
                    end
                end
                StFill: begin
                    cpu_ready_o  = 1'b1;
                    cpu_r_data_o = line_q[idx];
                end
                default: ;
            endcase
            if (state_q == StMiss) begin
                mem_r_en_o = 1'b1;
                mem_addr_o = {cpu_addr_i[31:2], 2'b00};
            end else if (wb_drain) begin
                mem_w_en_o   = wb_be_q[rd_ptr_q];
                mem_addr_o   = {wb_addr_q[rd_ptr_q], 2'b00};
                mem_w_data_o = wb_data_q[rd_ptr_q];
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hits_q, misses_q;
    logic        ld_idle;

    assign ld_idle = (state_q == StIdle) && cpu_r_en_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (ld_idle && hit && (hits_q != '1)) hits_q <= hits_q + 32'd1;
            if (ld_idle && !hit && (misses_q != '1)) misses_q <= misses_q + 32'd1;
        end
    end

    assign stat_hits_o   = hits_q;
    assign stat_misses_o = misses_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: architectural memory model predicts load data, a
// responder models the backing memory with configurable latency and stall control.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_w_data, cpu_r_data;
    logic        cpu_r_en, cpu_ready;
    logic [3:0]  cpu_w_en;
    logic [31:0] mem_addr, mem_w_data, mem_r_data;
    logic        mem_r_en, mem_ready;
    logic [3:0]  mem_w_en;
`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    always #5 clk = ~clk;

    data_cache dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cpu_addr_i   (cpu_addr),
        .cpu_r_en_i   (cpu_r_en),
        .cpu_w_en_i   (cpu_w_en),
        .cpu_w_data_i (cpu_w_data),
        .cpu_r_data_o (cpu_r_data),
        .cpu_ready_o  (cpu_ready),
        .mem_addr_o   (mem_addr),
        .mem_r_en_o   (mem_r_en),
        .mem_w_en_o   (mem_w_en),
        .mem_w_data_o (mem_w_data),
        .mem_r_data_i (mem_r_data),
        .mem_ready_i  (mem_ready)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits_o  (stat_hits),
        .stat_misses_o(stat_misses)
`endif
    );

    int          n_checks = 0;
    int          n_bad    = 0;
    logic [31:0] back_mem [1024];
    logic [31:0] ref_mem  [1024];
    logic [31:0] exp_q [$];
    logic [32:0] log_q [$];
    int          mem_lat   = 1;
    bit          mem_hold  = 0;
    int          pulse_req = 0;
    int          pulse_done = 0;
    bit          both_seen = 0;
    int          wait_cnt  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    // Backing memory responder: evaluates requests just after each rising edge.
    initial begin
        for (int i = 0; i < 1024; i++) back_mem[i] = init_word(i);
        back_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
        mem_ready  = 1'b0;
        mem_r_data = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ready = 1'b0;
            if (mem_r_en && (|mem_w_en)) both_seen = 1'b1;
            if (!rst && (mem_r_en || (|mem_w_en)) && (!mem_hold || pulse_req > pulse_done)) begin
                wait_cnt++;
                if (wait_cnt >= mem_lat) begin
                    wait_cnt  = 0;
                    mem_ready = 1'b1;
                    if (mem_hold) pulse_done++;
                    if (mem_r_en) begin
                        mem_r_data = back_mem[mem_addr[11:2]];
                        log_q.push_back({1'b0, mem_addr});
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (mem_w_en[b]) back_mem[mem_addr[11:2]][8*b +: 8] = mem_w_data[8*b +: 8];
                        end
                        log_q.push_back({1'b1, mem_addr});
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_load(input logic [31:0] a, output int cyc, output int rd_cyc,
                           output logic [31:0] rd_addr, output logic [31:0] rdata);
        bit done = 0;
        exp_q.push_back(ref_mem[a[11:2]]);
        cpu_addr = a; cpu_r_en = 1'b1; cpu_w_en = '0;
        cyc = 0; rd_cyc = -1; rd_addr = '0; rdata = '0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            if (mem_r_en && rd_cyc < 0) begin
                rd_cyc  = cyc;
                rd_addr = mem_addr;
            end
            if (cpu_ready) begin
                rdata = cpu_r_data;
                check_eq("load_data", cpu_r_data, exp_q.pop_front());
                done = 1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("load_done", done, 1);
        if (!done) exp_q.delete();
        cpu_r_en = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                            output int cyc);
        bit done = 0;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
        end
        cpu_addr = a; cpu_w_en = be; cpu_w_data = d; cpu_r_en = 1'b0;
        cyc = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            if (cpu_ready) done = 1;
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("store_done", done, 1);
        cpu_w_en = '0;
    endtask

    task automatic wait_drain();
        bit idle = 0;
        int k = 0;
        while (!idle && k < 100) begin
            @(negedge clk);
            if (mem_w_en == '0 && !mem_r_en) idle = 1;
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("drain_done", idle, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, rd_cyc, base;
        logic [31:0] rd_addr, rdata, a;
        logic [3:0]  be_tab [7];
        logic [32:0] got_log;
        logic [32:0] exp_log [3];

        be_tab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;

        // Reset with active requests on the inputs: all outputs must stay low.
        rst = 1'b1; cpu_addr = 32'h100; cpu_r_en = 1'b1; cpu_w_en = 4'hF; cpu_w_data = '1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_ctrl", {cpu_ready, mem_r_en, mem_w_en}, '0);
        check_eq("rst_mem_addr", mem_addr, '0);
        check_eq("rst_r_data", cpu_r_data, '0);
        check_eq("rst_w_data", mem_w_data, '0);
        @(posedge clk);
        #1;
        rst = 1'b0; cpu_r_en = 1'b0; cpu_w_en = '0;
        @(negedge clk);
        check_eq("idle_ready", cpu_ready, 1);
        @(posedge clk);
        #1;

        // 1: cold miss with memory answering in the third cycle of the request, then a hit.
        mem_lat = 3;
        do_load(32'h100, cyc, rd_cyc, rd_addr, rdata);
        check_eq("t1_latency", cyc, 5);
        check_eq("t1_rd_cyc", rd_cyc, 1);
        check_eq("t1_rd_addr", rd_addr, 32'h100);
        check_eq("t1_data", rdata, 32'hDEAD_BEEF);
        do_load(32'h100, cyc, rd_cyc, rd_addr, rdata);
        check_eq("t1_hit_cyc", cyc, 1);
        check_eq("t1_hit_no_rd", rd_cyc < 0, 1);

        // 2: store hit completes immediately, write appears on memory next cycle.
        mem_lat = 1;
        do_store(32'h100, 4'hF, 32'h1122_3344, cyc);
        check_eq("t2_store_cyc", cyc, 1);
        @(negedge clk);
        check_eq("t2_mem_wr", {mem_w_en, mem_addr}, {4'hF, 32'h100});
        check_eq("t2_mem_wdata", mem_w_data, 32'h1122_3344);
        @(posedge clk);
        #1;
        do_load(32'h100, cyc, rd_cyc, rd_addr, rdata);
        check_eq("t2_hit_cyc", cyc, 1);
        check_eq("t2_data", rdata, 32'h1122_3344);

        // 3: byte store merges into the cached line.
        do_store(32'h101, 4'b0010, 32'h0000_AA00, cyc);
        do_load(32'h100, cyc, rd_cyc, rd_addr, rdata);
        check_eq("t3_hit_cyc", cyc, 1);
        check_eq("t3_data", rdata, 32'h1122_AA44);

        // 4: full buffer stalls the fifth store until one write is acknowledged.
        wait_drain();
        mem_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h400 + 32'(4 * i), 4'hF, 32'hC0DE_0000 + 32'(i), cyc);
            check_eq("t4_accept_cyc", cyc, 1);
        end
        fork
            do_store(32'h410, 4'hF, 32'hC0DE_0004, cyc);
            begin
                repeat (4) @(posedge clk);
                #1;
                pulse_req++;
            end
        join
        check_eq("t4_stall_cyc", cyc, 6);
        mem_hold = 1'b0;
        wait_drain();
        for (int i = 0; i < 5; i++) check_eq("t4_mem", back_mem[256 + i], 32'hC0DE_0000 + 32'(i));

        // 5: buffered writes reach memory before the miss read is issued.
        base = log_q.size();
        mem_lat = 2;
        do_store(32'h500, 4'hF, 32'h5555_0000, cyc);
        do_store(32'h504, 4'hF, 32'h5555_0004, cyc);
        do_load(32'h300, cyc, rd_cyc, rd_addr, rdata);
        check_eq("t5_miss", rd_cyc >= 0, 1);
        check_eq("t5_log_len", log_q.size() - base, 3);
        exp_log = '{{1'b1, 32'h500}, {1'b1, 32'h504}, {1'b0, 32'h300}};
        for (int k = 0; k < 3; k++) begin
            got_log = (log_q.size() > base + k) ? log_q[base + k] : '1;
            check_eq("t5_order", got_log, exp_log[k]);
        end

        // 6: reset clears the lines; conflicting lines evict each other.
        wait_drain();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_lat = 1;
        do_load(32'h100, cyc, rd_cyc, rd_addr, rdata);
        check_eq("t6_miss_a", rd_cyc >= 0, 1);
        do_load(32'h200, cyc, rd_cyc, rd_addr, rdata);
        check_eq("t6_miss_b", rd_cyc >= 0, 1);
        do_load(32'h100, cyc, rd_cyc, rd_addr, rdata);
        check_eq("t6_miss_evict", rd_cyc >= 0, 1);
`ifdef DCACHE_STATS_EN
        check_eq("t6_stat_misses", stat_misses, 3);
        check_eq("t6_stat_hits", stat_hits, 0);
`endif

        // Random mix over conflicting lines with varying memory latency.
        for (int n = 0; n < 300; n++) begin
            mem_lat = $urandom_range(1, 3);
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 1) == 0) do_load(a, cyc, rd_cyc, rd_addr, rdata);
            else do_store(a, be_tab[$urandom_range(0, 6)], $urandom, cyc);
        end
        wait_drain();
        for (int i = 0; i < 1024; i++) check_eq("final_mem", back_mem[i], ref_mem[i]);
        check_eq("rw_exclusive", both_seen, 0);
        check_eq("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
